result_demux6: RTL
==================

# result_demux6

Registered 1-to-6 result distributor for the multicycle datapath: the write-side counterpart of the 16-bit 6-to-1 source mux. Accepts one data word plus a 3-bit destination select through a valid/ready handshake. Presents the word on a shared output bus with a per-destination valid, holding it until the chosen destination accepts. Sits between the ALU/memory result bus and the six datapath destination registers.

## Interface
Parameters:
- WIDTH, 16, data word width
- CNT_W, 8, width of the completed-transfer counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  producer has a word
- in_ready  out  1  block can accept a word
- in_sel  in  3  destination select
- in_data  in  WIDTH  word to deliver
- out_data  out  WIDTH  captured word, shared by all destinations
- out_valid  out  6  per-destination valid, bit i targets destination i
- out_ready  in  6  per-destination accept
- busy  out  1  a transfer is pending
- xfer_cnt  out  CNT_W  completed transfers, saturating

## Operation
- States: IDLE, SEND.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready:
    - capture in_data into out_data
    - load pending mask from in_sel
    - go to SEND
- Select decode mirrors the source mux:
  - sel 0..4 → destination 0..4 (one-hot)
  - sel 5, 6, 7 → destination 5
  - Exception: sel 7 under broadcast; see Configuration.
- SEND:
  - in_ready = 0; out_valid = pending mask; busy = 1.
  - Each bit i with out_valid[i] && out_ready[i] clears at the clock edge.
  - When the mask clears (all bits clear, possibly several in one edge), go to IDLE and increment xfer_cnt by 1.
- out_ready bits for non-pending destinations are ignored.
- out_data is stable for the whole of SEND. It keeps its last value in IDLE and does not return to 0.
- xfer_cnt saturates at 2^CNT_W−1 and never wraps.
- in_sel and in_data are sampled only on the accept edge. Changes while in SEND have no effect.

## Timing
- Reset (asynchronous, rst_n low), all outputs:
  - state = IDLE; in_ready = 1 (combinational from state)
  - out_data = 0, out_valid = 0, busy = 0, xfer_cnt = 0
- Reset asserted mid-SEND discards the pending transfer with no count increment. After release, the block is in IDLE.
- Accept at edge N → out_valid/out_data/busy valid immediately after edge N.
- Destination ready in the cycle after edge N → handshake at edge N+1, IDLE after N+1, next accept at edge N+2.
  - Peak throughput: one word per 2 cycles.
- Destination ready held low → out_valid held indefinitely. No timeout.
- in_ready is a function of registered state only; no combinational path from out_ready to in_ready.

## Configuration
- Macro: RESULT_DEMUX6_BCAST_EN.
- Defined:
  - in_sel = 7 loads pending mask 6'b111111 (broadcast).
  - Destinations may accept on different cycles; each bit clears independently.
  - Transfer completes and counts once, when the last bit clears.
- Undefined:
  - in_sel = 7 maps to destination 5, like sel 5 and 6.
  - No multi-bit mask logic is generated.

## Structure
- Shared package holds:
  - state enum (IDLE, SEND)
  - NUM_DEST = 6
  - SEL_W = 3
  - SEL_BCAST = 3'd7
- Sub-module sel_decode6: combinational sel → 6-bit mask.
  - Contains the only use of RESULT_DEMUX6_BCAST_EN.
- Top contains the FSM, data register, mask register and counter.

## Test plan
- Reset: drive rst_n low mid-SEND with out_valid = 6'b000100 → out_valid = 0, out_data = 0, xfer_cnt = 0, in_ready = 1 immediately. Operation is normal after release.
- Single transfer:
  - Stimulus: sel = 2, data = 16'hBEEF, out_ready = 6'b111111.
  - Required: out_valid = 6'b000100 for exactly one cycle, out_data = 16'hBEEF, xfer_cnt = 1, in_ready low for one cycle.
- Aliasing (without macro): sel = 5, 6, 7 in turn → out_valid = 6'b100000 each time; xfer_cnt = 3.
- Backpressure:
  - Stimulus: sel = 0, out_ready[0] low for 5 cycles, other ready bits high.
  - Required: out_valid[0] and out_data held for 5 cycles, in_ready = 0 throughout, a new in_valid is not accepted, completion occurs on the 6th cycle.
- Broadcast (with macro):
  - Stimulus: sel = 7, data = 16'h1234; out_ready rises on bits 0 and 3 first, then the other bits 2 cycles later.
  - Required: out_valid goes 6'b111111 → 6'b110110 → 0; xfer_cnt increments once.
- Saturation: CNT_W = 2, run 5 back-to-back transfers → xfer_cnt = 3 after transfers 3, 4 and 5.

Source files
------------

// File: rtl/result_demux6_pkg.sv
// Shared types and constants for the 1-to-6 result distributor.
package result_demux6_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   localparam int NUM_DEST = 6;
   localparam int SEL_W = 3;
   localparam logic [SEL_W-1:0] SEL_BCAST = 3'd7;

endpackage : result_demux6_pkg

// File: rtl/result_demux6_sel_decode6.sv
// Destination select decoder: 3-bit select to 6-bit destination mask.
// RESULT_DEMUX6_BCAST_EN turns select 7 into a broadcast to all destinations.
module result_demux6_sel_decode6
   import result_demux6_pkg::*;
(
   input  logic [SEL_W-1:0]    i_sel,
   output logic [NUM_DEST-1:0] o_mask
);

   // Selects 5..7 alias onto destination 5, mirroring the source mux.
   always_comb begin
      o_mask = 6'b000000;
      case (i_sel)
         3'd0:      o_mask = 6'b000001;
         3'd1:      o_mask = 6'b000010;
         3'd2:      o_mask = 6'b000100;
         3'd3:      o_mask = 6'b001000;
         3'd4:      o_mask = 6'b010000;
         3'd5,
         3'd6:      o_mask = 6'b100000;
`ifdef RESULT_DEMUX6_BCAST_EN
         SEL_BCAST: o_mask = 6'b111111;
`else
         SEL_BCAST: o_mask = 6'b100000;
`endif
         default:   o_mask = 6'b000000;
      endcase
   end

endmodule : result_demux6_sel_decode6

// File: rtl/result_demux6.sv
// Registered 1-to-6 result distributor with valid/ready on both sides.
// Broadcast on select 7 is enabled by RESULT_DEMUX6_BCAST_EN (see the decoder).
module result_demux6
   import result_demux6_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [SEL_W-1:0]    in_sel,
   input  logic [WIDTH-1:0]    in_data,
   output logic [WIDTH-1:0]    out_data,
   output logic [NUM_DEST-1:0] out_valid,
   input  logic [NUM_DEST-1:0] out_ready,
   output logic                busy,
   output logic [CNT_W-1:0]    xfer_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t              r_state;
   state_t              w_state_next;
   logic [WIDTH-1:0]    r_data;
   logic [NUM_DEST-1:0] r_mask;
   logic [NUM_DEST-1:0] w_mask_next;
   logic [NUM_DEST-1:0] w_dec_mask;
   logic [NUM_DEST-1:0] w_mask_left;
   logic [CNT_W-1:0]    r_cnt;
   logic                w_accept;
   logic                w_done;

   result_demux6_sel_decode6 u_sel_decode (
      .i_sel  (in_sel),
      .o_mask (w_dec_mask)
   );

   assign w_accept    = (r_state == IDLE) && in_valid;
   assign w_mask_left = r_mask & ~out_ready;

   // Next-state and pending-mask logic; the mask is empty whenever the FSM is idle.
   always_comb begin
      w_state_next = r_state;
      w_mask_next  = r_mask;
      w_done       = 1'b0;
      case (r_state)
         IDLE: begin
            if (in_valid) begin
               w_state_next = SEND;
               w_mask_next  = w_dec_mask;
            end else begin
               w_state_next = IDLE;
               w_mask_next  = 6'b000000;
            end
         end
         SEND: begin
            w_mask_next = w_mask_left;
            if (w_mask_left == 6'b000000) begin
               w_state_next = IDLE;
               w_done       = 1'b1;
            end else begin
               w_state_next = SEND;
            end
         end
         default: begin
            w_state_next = IDLE;
            w_mask_next  = 6'b000000;
         end
      endcase
   end

   // State and pending-mask registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_mask  <= 6'b000000;
      end else begin
         r_state <= w_state_next;
         r_mask  <= w_mask_next;
      end
   end

   // Data word is captured only on the accept edge and held through idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data <= '0;
      end else if (w_accept) begin
         r_data <= in_data;
      end
   end

   // Completed-transfer counter, saturating at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (w_done && (r_cnt != CNT_MAX)) begin
         r_cnt <= r_cnt + CNT_ONE;
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign busy      = (r_state == SEND);
   assign out_valid = r_mask;
   assign out_data  = r_data;
   assign xfer_cnt  = r_cnt;

endmodule : result_demux6
